uart_tx_scheduler: RTL

//  Shares one UART transmitter (start/txin/txdone interface) between N_REQ byte requesters.

---
 rtl/uart_pkg.sv | 30 +++
 rtl/uart_rr_arbiter.sv | 43 ++++
 rtl/uart_tx_scheduler.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared types and helpers for the UART transmit scheduler:
//                2-bit FSM state encoding, default byte width, width helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // Default byte width, matches the UART txin port
    localparam int c_data_w_default = 8;

    // Scheduler FSM state encoding
    localparam logic [1:0] c_st_idle      = 2'd0;
    localparam logic [1:0] c_st_launch    = 2'd1;
    localparam logic [1:0] c_st_wait_done = 2'd2;
    localparam logic [1:0] c_st_gap       = 2'd3;

    // Width of a requester index; never narrower than one bit
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Width of a counter that must hold max_val; never narrower than one bit
    function automatic int cnt_width(input int max_val);
        return (max_val > 0) ? $clog2(max_val + 1) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rr_arbiter
//  Description : Combinational round-robin pick. Scans ptr, ptr+1, ...
//                (mod N_REQ) and returns the first asserted request.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rr_arbiter
    import uart_pkg::*;
#(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]           req,
    input  logic [id_width(N_REQ)-1:0] ptr,
    output logic [id_width(N_REQ)-1:0] grant,
    output logic                       found
);

    localparam int c_id_w = id_width(N_REQ);

    // Walk offsets from farthest to nearest so the nearest request to ptr wins
    always_comb begin : p_scan
        int                w_idx;
        logic [c_id_w-1:0] w_sel;
        grant = '0;
        found = 1'b0;
        w_idx = 0;
        w_sel = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            w_idx = int'(ptr) + k;
            if (w_idx >= N_REQ) begin
                w_idx = w_idx - N_REQ;
            end
            w_sel = w_idx[c_id_w-1:0];
            if (req[w_sel]) begin
                grant = w_sel;
                found = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_scheduler
//  Description : Shares one UART transmitter between N_REQ byte requesters.
//                Round-robin grant, start pulse, data hold until txdone,
//                inter-frame gap, and a watchdog that aborts hung frames.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_scheduler
    import uart_pkg::*;
#(
    parameter int N_REQ      = 4,
    parameter int DATA_W     = c_data_w_default,
    parameter int GAP_CYCLES = 16,
    parameter int TIMEOUT    = 20000
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N_REQ-1:0]           req_valid,
    input  logic [N_REQ*DATA_W-1:0]    req_data,
    output logic [N_REQ-1:0]           req_ack,
    output logic [N_REQ-1:0]           req_done,
    output logic                       uart_start,
    output logic [DATA_W-1:0]          uart_txin,
    input  logic                       uart_txdone,
    output logic [id_width(N_REQ)-1:0] grant_id,
    output logic                       busy,
    output logic                       err_timeout
);

    localparam int c_id_w  = id_width(N_REQ);
    localparam int c_wd_w  = cnt_width(TIMEOUT);
    localparam int c_gap_w = cnt_width(GAP_CYCLES);

    localparam logic [c_id_w-1:0]  c_id_one   = c_id_w'(1);
    localparam logic [c_id_w-1:0]  c_id_last  = c_id_w'(N_REQ - 1);
    localparam logic [c_wd_w-1:0]  c_wd_one   = c_wd_w'(1);
    localparam logic [c_wd_w-1:0]  c_wd_last  = c_wd_w'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [c_gap_w-1:0] c_gap_one  = c_gap_w'(1);
    // A gap of zero or one cycle both leave GAP after a single cycle
    localparam logic [c_gap_w-1:0] c_gap_last = c_gap_w'((GAP_CYCLES > 1) ? GAP_CYCLES - 1 : 0);

    logic [1:0]          r_state;
    logic [c_id_w-1:0]   r_ptr;
    logic [c_id_w-1:0]   r_grant_id;
    logic [DATA_W-1:0]   r_txin;
    logic [N_REQ-1:0]    r_ack;
    logic [N_REQ-1:0]    r_done;
    logic                r_start;
    logic                r_busy;
    logic                r_err;
    logic [c_wd_w-1:0]   r_wd;
    logic [c_gap_w-1:0]  r_gap_cnt;

    logic [c_id_w-1:0]   w_grant;
    logic                w_found;
    logic [DATA_W-1:0]   w_lane [N_REQ];
    logic [DATA_W-1:0]   w_sel_data;
    logic [N_REQ-1:0]    w_grant_oh;
    logic [c_id_w-1:0]   w_ptr_next;

    uart_rr_arbiter #(
        .N_REQ (N_REQ)
    ) u_arb (
        .req   (req_valid),
        .ptr   (r_ptr),
        .grant (w_grant),
        .found (w_found)
    );

    // Split the flat data bus into per-requester lanes
    for (genvar g = 0; g < N_REQ; g++) begin : g_lane
        assign w_lane[g] = req_data[g*DATA_W +: DATA_W];
    end

    // Byte of the winner, one-hot of the active grant, and the next rr pointer
    always_comb begin
        w_sel_data             = w_lane[w_grant];
        w_grant_oh             = '0;
        w_grant_oh[r_grant_id] = 1'b1;
        w_ptr_next             = (r_grant_id == c_id_last) ? '0 : r_grant_id + c_id_one;
    end

    // Scheduler FSM with registered handshake, data and status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= c_st_idle;
            r_ptr      <= '0;
            r_grant_id <= '0;
            r_txin     <= '0;
            r_ack      <= '0;
            r_done     <= '0;
            r_start    <= 1'b0;
            r_busy     <= 1'b0;
            r_err      <= 1'b0;
            r_wd       <= '0;
            r_gap_cnt  <= '0;
        end else begin
            r_start <= 1'b0;
            r_ack   <= '0;
            r_done  <= '0;
            case (r_state)
                c_st_idle: begin
                    if (w_found) begin
                        r_grant_id <= w_grant;
                        r_txin     <= w_sel_data;
                        r_busy     <= 1'b1;
                        r_state    <= c_st_launch;
                    end
                end
                c_st_launch: begin
                    r_start <= 1'b1;
                    r_ack   <= w_grant_oh;
                    r_wd    <= '0;
                    r_state <= c_st_wait_done;
                end
                c_st_wait_done: begin
                    // txdone is checked first so it wins over a same-cycle expiry
                    if (uart_txdone) begin
                        r_done    <= w_grant_oh;
                        r_ptr     <= w_ptr_next;
                        r_gap_cnt <= '0;
                        r_state   <= c_st_gap;
                    end else if (r_wd == c_wd_last) begin
                        r_err     <= 1'b1;
                        r_ptr     <= w_ptr_next;
                        r_gap_cnt <= '0;
                        r_state   <= c_st_gap;
                    end else if (r_wd != '1) begin
                        r_wd <= r_wd + c_wd_one;
                    end
                end
                c_st_gap: begin
                    if (r_gap_cnt == c_gap_last) begin
                        r_busy  <= 1'b0;
                        r_state <= c_st_idle;
                    end else if (r_gap_cnt != '1) begin
                        r_gap_cnt <= r_gap_cnt + c_gap_one;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    assign req_ack     = r_ack;
    assign req_done    = r_done;
    assign uart_start  = r_start;
    assign uart_txin   = r_txin;
    assign grant_id    = r_grant_id;
    assign busy        = r_busy;
    assign err_timeout = r_err;

endmodule
`default_nettype wire
